// File: rtl/rv32_pipe_pkg.sv
// Shared fetch/decode pipeline definitions: datapath width, bubble instruction,
// and the occupancy states of the IF/ID skid stage.
package rv32_pipe_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StBusy  = 2'd1,
        StFull  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_data_reg.sv
// Load-enabled {pc, instr} holding register; resets to {0, bubble instruction}.
module pipe_data_reg #(
    parameter int unsigned      Width      = 32,
    parameter logic [Width-1:0] ResetInstr = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Width-1:0] d_pc,
    input  logic [Width-1:0] d_instr,
    output logic [Width-1:0] q_pc,
    output logic [Width-1:0] q_instr
);

    logic [Width-1:0] pc_q;
    logic [Width-1:0] instr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= '0;
            instr_q <= ResetInstr;
        end else if (load) begin
            pc_q    <= d_pc;
            instr_q <= d_instr;
        end
    end

    assign q_pc    = pc_q;
    assign q_instr = instr_q;

endmodule

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline register with a one-entry skid buffer so in_ready is fully
// registered; also counts decode back-pressure cycles.
module if_id_skid_stage
    import rv32_pipe_pkg::*;
#(
    parameter int unsigned     XLEN      = rv32_pipe_pkg::XLEN,
    parameter logic [XLEN-1:0] NOP_INSTR = rv32_pipe_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    input  logic            flush,
    output logic [15:0]     stall_cnt
);

    pipe_state_e state_q, state_d;

    logic            in_hs, out_hs;
    logic            load_main, load_skid, main_from_skid;
    logic [XLEN-1:0] main_pc, main_instr, skid_pc, skid_instr;
    logic [XLEN-1:0] main_pc_d, main_instr_d;
    logic [15:0]     stall_cnt_q, stall_cnt_d;

    assign in_ready  = (state_q != StFull);
    assign out_valid = (state_q != StEmpty);
    assign in_hs     = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            StEmpty: begin
                if (in_hs) begin
                    load_main = 1'b1;
                    state_d   = StBusy;
                end
            end
            StBusy: begin
                if (in_hs && out_hs) begin
                    load_main = 1'b1;
                end else if (in_hs) begin
                    load_skid = 1'b1;
                    state_d   = StFull;
                end else if (out_hs) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (out_hs) begin
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = StBusy;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Redirect wins over everything; loads are blocked so out_pc keeps its value.
        if (flush) begin
            state_d   = StEmpty;
            load_main = 1'b0;
            load_skid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    assign main_pc_d    = main_from_skid ? skid_pc    : in_pc;
    assign main_instr_d = main_from_skid ? skid_instr : in_instr;

    pipe_data_reg #(
        .Width      (XLEN),
        .ResetInstr (NOP_INSTR)
    ) u_main_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (load_main),
        .d_pc    (main_pc_d),
        .d_instr (main_instr_d),
        .q_pc    (main_pc),
        .q_instr (main_instr)
    );

    pipe_data_reg #(
        .Width      (XLEN),
        .ResetInstr (NOP_INSTR)
    ) u_skid_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (load_skid),
        .d_pc    (in_pc),
        .d_instr (in_instr),
        .q_pc    (skid_pc),
        .q_instr (skid_instr)
    );

    assign out_pc    = main_pc;
    assign out_instr = out_valid ? main_instr : NOP_INSTR;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/if_id_skid_stage.md
IF_ID_SKID_STAGE -- requirements
Module: if_id_skid_stage

Interface
REQ-001 Parameter XLEN, default 32, is the width of the PC and instruction fields.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), is the instruction presented on bubbles.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  fetch stage offers {in_pc, in_instr}.
REQ-006 Port in_ready  output  1  stage can accept a fetch word this cycle.
REQ-007 Port in_pc  input  XLEN  PC of the offered instruction.
REQ-008 Port in_instr  input  XLEN  offered instruction word.
REQ-009 Port out_valid  output  1  decode-side word is valid.
REQ-010 Port out_ready  input  1  decode stage consumes the word this cycle.
REQ-011 Port out_pc  output  XLEN  PC presented to decode.
REQ-012 Port out_instr  output  XLEN  instruction presented to decode.
REQ-013 Port flush  input  1  branch/jump redirect; discards all held words.
REQ-014 Port stall_cnt  output  16  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-015 Storage SHALL be a main register and a skid register, each holding {pc, instr}; state SHALL be EMPTY, BUSY (main full), or FULL (main and skid full).
REQ-016 Input handshake occurs when in_valid=1 and in_ready=1; output handshake occurs when out_valid=1 and out_ready=1.
REQ-017 in_ready SHALL equal (state != FULL) and SHALL depend only on registered state, with no combinational path from out_ready.
REQ-018 out_valid SHALL equal (state != EMPTY); out_pc/out_instr SHALL come from the main register.
REQ-019 When out_valid=0, out_instr SHALL be NOP_INSTR and out_pc SHALL hold its last value.
REQ-020 EMPTY: on input handshake, load main and go to BUSY; otherwise stay.
REQ-021 BUSY: input only -> load skid, go to FULL; output only -> go to EMPTY; both -> load main with input, stay BUSY; neither -> hold.
REQ-022 FULL: on output handshake, main <= skid, go to BUSY; otherwise hold. No input is accepted.
REQ-023 Ordering SHALL be strict FIFO: no word is dropped, duplicated, or reordered absent flush.
REQ-024 Latency SHALL be one cycle: a word accepted in cycle N is on out_* with out_valid=1 in cycle N+1.
REQ-025 flush=1 SHALL force next state EMPTY and SHALL take priority over any simultaneous input or output handshake; the offered input word is discarded.
REQ-026 in_ready SHALL not be masked by flush; upstream treats a flushed handshake as dropped.
REQ-027 stall_cnt SHALL increment by 1 each cycle with out_valid=1 and out_ready=0, SHALL saturate at 16'hFFFF, and SHALL be unaffected by flush.

Reset
REQ-028 While rst=0: state EMPTY, in_ready=1, out_valid=0, main/skid pc=0, main/skid instr=NOP_INSTR, stall_cnt=0.
REQ-029 Reset assertion mid-operation SHALL discard held words immediately, without waiting for clk.
REQ-030 The first input handshake SHALL occur no earlier than the first rising clk edge after rst deasserts.

Structure
REQ-031 The shared package rv32_pipe_pkg SHALL hold XLEN, NOP_INSTR, and the EMPTY/BUSY/FULL state enum.
REQ-032 Both storage slots SHALL instantiate one sub-module, pipe_data_reg (load-enabled {pc, instr} register with async active-low reset to {0, NOP_INSTR}).
REQ-033 Control SHALL be one FSM; there SHALL be no combinational in->out bypass.

Verification
REQ-034 Reset then single word: pc=0x100, instr=0x00500093 with out_ready=1 -> out_valid=1 next cycle with the same values, and EMPTY afterwards.
REQ-035 Back-pressure: out_ready=0, offer 0x100 then 0x104 -> FULL, in_ready=0; raise out_ready -> 0x100 then 0x104 in order; stall_cnt equals the stalled cycles.
REQ-036 Streaming: in_valid=1 and out_ready=1 for 10 cycles, pc 0x0..0x24 -> one word per cycle, no gaps, in_ready stays 1.
REQ-037 Flush in FULL with a simultaneous input 0x200 -> next cycle out_valid=0, out_instr=0x00000013, and 0x200 never appears.
REQ-038 Assert rst=0 asynchronously in FULL -> out_valid=0 and stall_cnt=0 before the next clk edge; hold out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=0xFFFF.
